complex_stream_assembler: RTL
=============================

# complex_stream_assembler

Receive-side assembler for the 64-bit complex word format (real single-precision float in [63:32], imaginary in [31:0]). Accepts a stream of 32-bit halves (real first, then imaginary) over a valid/ready handshake. Optionally undoes a transmit-side conjugation by negating the imaginary half. Presents whole complex words to downstream arithmetic on a registered valid/ready output.

## Interface
- CNT_W, 16, width of the emitted-word counter

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on the next rising edge
- in_data  input  32  half-word: real on the first beat, imaginary on the second
- in_valid  input  1  in_data/in_last/conj_en valid
- in_ready  output  1  assembler accepts the beat this cycle
- in_last  input  1  marks the final beat of a frame; legal only on an imaginary beat
- conj_en  input  1  sampled with the real beat; 1 = negate imaginary half of this word
- out_data  output  64  assembled word {real, imag}
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  downstream accepts out_data this cycle
- out_last  output  1  word closes a frame; qualified by out_valid
- frame_err  output  1  one-cycle pulse: in_last seen on a real beat
- word_count  output  CNT_W  number of words handed off downstream since reset

## Operation
- A beat transfers when in_valid && in_ready. A word transfers when out_valid && out_ready.
- Two-state FSM, `S_REAL` and `S_IMAG`. Reset state is `S_REAL`.
- `S_REAL`:
  - in_ready = 1.
  - On a beat, latch in_data into real_q and conj_en into conj_q, then go to `S_IMAG`.
  - Exception: if in_last = 1 on this beat, discard it, pulse frame_err on the next cycle, and stay in `S_REAL`.
- `S_IMAG`:
  - in_ready = !out_valid || out_ready. The output register is free or is being drained this same cycle.
  - On a beat, load out_data = {real_q, imag'}, out_last = in_last, set out_valid, then return to `S_REAL`.
- Negation: imag' = conj_q ? {~in_data[31], in_data[30:0]} : in_data. This is a pure sign-bit flip, applied to zeros, infinities and NaNs alike. No rounding and no flag changes.
- out_valid clears on a word transfer unless a new word loads in the same cycle. Simultaneous drain and load keeps out_valid = 1 and replaces the data.
- word_count increments by 1 on every word transfer and wraps from 2^CNT_W−1 to 0.
- out_data, out_last and out_valid change only on load or drain. They hold steady while out_valid && !out_ready.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_last = 0, frame_err = 0, word_count = 0, state = `S_REAL`.
- Reset mid-word discards the held real half. Reset with out_valid = 1 drops the pending word without a handshake.
- Latency: the imaginary beat accepted in cycle N gives out_valid = 1 in cycle N+1.
- Sustained throughput is one word per two clocks. The real beat is accepted even while out_valid && !out_ready, so it overlaps with output backpressure.
- in_ready is combinational from the state, out_valid and out_ready. There is no combinational path from in_valid to in_ready.
- frame_err is high for exactly the one cycle after the offending beat.
- conj_en and in_last are ignored on beats where they are not defined: conj_en on imaginary beats, in_last when no beat transfers.

## Test plan
- Basic pass-through:
  - Stimulus: conj_en = 0, beats 0x3F800000 then 0x40000000, out_ready = 1.
  - Response: out_data = 0x3F800000_40000000 one cycle after the second beat; word_count = 1.
- Conjugation:
  - Stimulus: conj_en = 1, beats 0x3F800000 then 0x40000000.
  - Response: out_data = 0x3F800000_C0000000.
  - Repeat with imaginary 0x00000000; response out_data[31:0] = 0x80000000.
- Backpressure:
  - Stimulus: out_ready = 0 with 3 words offered back-to-back.
  - Response: first word held stable; the second real beat is accepted; the second imaginary beat stalls (in_ready = 0).
  - Then raise out_ready: all 3 words emerge in order and word_count = 3.
- Frame marking and error:
  - Stimulus: in_last on the 4th beat.
  - Response: out_last = 1 on the 2nd word only.
  - Stimulus: in_last on a real beat.
  - Response: frame_err pulses for 1 cycle, no word is emitted, and the next two beats form a clean word.
- Reset mid-operation:
  - Stimulus: assert reset after a real beat with out_valid = 1.
  - Response: next cycle out_valid = 0 and word_count = 0; the next two beats form a word from fresh data only.
- Counter wrap:
  - Stimulus: CNT_W = 4, 17 words.
  - Response: word_count = 1.

Source files
------------

// File: rtl/complex_stream_assembler_if.sv
// complex_stream_assembler_if: half-word input stream and complex-word output stream
interface complex_stream_assembler_if #(parameter int CNT_W = 16);
  logic [31:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic             conj_en;
  logic [63:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             frame_err;
  logic [CNT_W-1:0] word_count;
  modport master (
    output in_data, in_valid, in_last, conj_en, out_ready,
    input  in_ready, out_data, out_valid, out_last, frame_err, word_count
  );
  modport slave (
    input  in_data, in_valid, in_last, conj_en, out_ready,
    output in_ready, out_data, out_valid, out_last, frame_err, word_count
  );
endinterface

// File: rtl/complex_stream_assembler.sv
// complex_stream_assembler: pairs real/imag 32-bit halves into registered 64-bit complex words
module complex_stream_assembler #(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  complex_stream_assembler_if.slave s
);
  typedef enum logic {S_REAL, S_IMAG} state_t;
  state_t           state_q, state_d;
  logic [31:0]      real_q, real_d;
  logic             conj_q, conj_d;
  logic [63:0]      out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready, beat, drain;
  always_comb begin
    in_ready    = state_q == S_REAL ? 1'b1 : !out_valid_q || s.out_ready;
    beat        = s.in_valid && in_ready;
    drain       = out_valid_q && s.out_ready;
    state_d     = state_q;
    real_d      = real_q;
    conj_d      = conj_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = drain ? 1'b0 : out_valid_q;
    frame_err_d = 1'b0;
    count_d     = count_q + CNT_W'(drain);
    // a last marker on a real beat is a framing error: the beat is dropped
    if (beat && state_q == S_REAL) begin
      frame_err_d = s.in_last;
      if (!s.in_last) begin
        real_d  = s.in_data;
        conj_d  = s.conj_en;
        state_d = S_IMAG;
      end
    end
    if (beat && state_q == S_IMAG) begin
      out_data_d  = {real_q, s.in_data[31] ^ conj_q, s.in_data[30:0]};
      out_last_d  = s.in_last;
      out_valid_d = 1'b1;
      state_d     = S_REAL;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_REAL;
      real_q      <= '0;
      conj_q      <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      real_q      <= real_d;
      conj_q      <= conj_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      count_q     <= count_d;
    end
  end
  assign s.in_ready   = in_ready;
  assign s.out_data   = out_data_q;
  assign s.out_last   = out_last_q;
  assign s.out_valid  = out_valid_q;
  assign s.frame_err  = frame_err_q;
  assign s.word_count = count_q;
endmodule
